// File: rtl/float_mult_arbiter.sv
// Round-robin arbiter that shares one float multiplier among NUM_REQ requesters.
// Holds the product, flags and owner ID on a single result port until accepted.

module float_multiplier #(
  parameter int unsigned FLOAT_SIZE    = 32,
  parameter int unsigned EXPONENT_SIZE = 8,
  parameter int unsigned MANTISSA_SIZE = 23,
  parameter int unsigned BIAS          = 127
) (
  input  logic [FLOAT_SIZE-1:0] a,
  input  logic [FLOAT_SIZE-1:0] b,
  output logic [FLOAT_SIZE-1:0] result,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  inexact
);
  localparam int unsigned M  = MANTISSA_SIZE;
  localparam int unsigned E  = EXPONENT_SIZE;
  localparam int unsigned PW = 2 * (M + 1);
  localparam int unsigned XW = E + 2;

  logic [M:0]      ma;
  logic [M:0]      mb;
  logic [PW-1:0]   prod;
  logic            norm;
  logic [XW-1:0]   exp_full;
  logic [M-1:0]    mant;

  assign ma   = {1'b1, a[M-1:0]};
  assign mb   = {1'b1, b[M-1:0]};
  assign prod = PW'(ma) * PW'(mb);
  assign norm = prod[PW-1];

  // Two guard bits above the exponent: top bit means negative, next means too large.
  assign exp_full = XW'(a[FLOAT_SIZE-2 -: E]) + XW'(b[FLOAT_SIZE-2 -: E])
                  - XW'(BIAS) + XW'(norm);

  assign mant      = norm ? prod[PW-2 -: M] : prod[PW-3 -: M];
  assign inexact   = norm ? (|prod[M:0]) : (|prod[M-1:0]);
  assign underflow = exp_full[XW-1];
  assign overflow  = !exp_full[XW-1] && exp_full[E];
  assign result    = {a[FLOAT_SIZE-1] ^ b[FLOAT_SIZE-1], exp_full[E-1:0], mant};
endmodule

module float_mult_arbiter #(
  parameter int unsigned FLOAT_SIZE    = 32,
  parameter int unsigned EXPONENT_SIZE = 8,
  parameter int unsigned MANTISSA_SIZE = 23,
  parameter int unsigned BIAS          = 127,
  parameter int unsigned NUM_REQ       = 4,
  localparam int unsigned ID_W         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*FLOAT_SIZE-1:0] req_a,
  input  logic [NUM_REQ*FLOAT_SIZE-1:0] req_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ID_W-1:0]               res_id,
  output logic [FLOAT_SIZE-1:0]         res_out,
  output logic                          res_overflow,
  output logic                          res_underflow,
  output logic                          res_inexact,
  output logic                          busy
);
  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         last_q, last_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [FLOAT_SIZE-1:0]   a_q, a_d;
  logic [FLOAT_SIZE-1:0]   b_q, b_d;
  logic [FLOAT_SIZE-1:0]   res_out_q, res_out_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic                    inx_q, inx_d;
  logic                    busy_q, busy_d;
  logic                    res_valid_q, res_valid_d;

  logic [FLOAT_SIZE-1:0]   a_arr [NUM_REQ];
  logic [FLOAT_SIZE-1:0]   b_arr [NUM_REQ];
  logic                    grant_found;
  logic [ID_W-1:0]         grant_idx;
  int unsigned             cand;

  logic [FLOAT_SIZE-1:0]   mul_out;
  logic                    mul_ovf, mul_unf, mul_inx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*FLOAT_SIZE +: FLOAT_SIZE];
    assign b_arr[i] = req_b[i*FLOAT_SIZE +: FLOAT_SIZE];
  end

  float_multiplier #(
    .FLOAT_SIZE    (FLOAT_SIZE),
    .EXPONENT_SIZE (EXPONENT_SIZE),
    .MANTISSA_SIZE (MANTISSA_SIZE),
    .BIAS          (BIAS)
  ) u_mul (
    .a         (a_q),
    .b         (b_q),
    .result    (mul_out),
    .overflow  (mul_ovf),
    .underflow (mul_unf),
    .inexact   (mul_inx)
  );

  // Round-robin search starting just after the most recent grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    res_out_d   = res_out_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inx_d       = inx_q;
    req_ready   = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_found && !reset) begin
          req_ready[grant_idx] = 1'b1;
          a_d     = a_arr[grant_idx];
          b_d     = b_arr[grant_idx];
          id_d    = grant_idx;
          last_d  = grant_idx;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        res_out_d = mul_out;
        ovf_d     = mul_ovf;
        unf_d     = mul_unf;
        inx_d     = mul_inx;
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    res_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_q      <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_out_q   <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_out_q   <= res_out_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inx_q       <= inx_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_valid     = res_valid_q;
  assign res_id        = id_q;
  assign res_out       = res_out_q;
  assign res_overflow  = ovf_q;
  assign res_underflow = unf_q;
  assign res_inexact   = inx_q;
  assign busy          = busy_q;
endmodule
